// File: rtl/bram_read_arbiter.sv
// Shares one BRAM read port among burst requesters, issuing sequential word reads and routing returned words back to the owner.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; otherwise arbitration is round-robin.
module bram_read_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 2,
    parameter int LEN_WIDTH    = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic                          bram_en,
    input  logic [DATA_WIDTH-1:0]         bram_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            hold,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy
);

    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [OWN_W-1:0]      owner;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [READ_LATENCY-1:0] vld_p;
    logic [OWN_W-1:0]      own_p [READ_LATENCY];

    logic                  grant_any;
    logic [OWN_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [LEN_WIDTH-1:0]  grant_len;
    logic                  owner_hold;
    logic                  pending;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
        onehot = NUM_REQ'(1) << idx;
    endfunction

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = OWN_W'(i);
            end
        end
    end
`else
    logic [OWN_W-1:0]       rr_ptr;
    logic [OWN_W-1:0]       next_ptr;
    logic [2*NUM_REQ-1:0]   req_rot;
    int                     cand;
    int                     nxt;

    // Rotate requests so the search starts at the index after the last grant
    always_comb begin
        req_rot   = {req_valid, req_valid} >> rr_ptr;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_any = 1'b1;
                cand      = int'(rr_ptr) + i;
            end
        end
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        grant_idx = OWN_W'(cand);
        nxt = int'(grant_idx) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        next_ptr = OWN_W'(nxt);
    end
`endif

    always_comb begin
        grant_addr = '0;
        grant_len  = '0;
        owner_hold = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == OWN_W'(i)) begin
                grant_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                grant_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
            if (owner == OWN_W'(i)) owner_hold = hold[i];
        end
    end

    // Words still owed: the address on the port now plus all but the stage about to retire
    always_comb begin
        pending = bram_en;
        for (int i = 0; i < READ_LATENCY - 1; i++) pending = pending | vld_p[i];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            cur_addr  <= '0;
            remaining <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
            bram_addr <= '0;
            bram_en   <= 1'b0;
            req_ready <= '0;
            rd_data   <= '0;
            rd_valid  <= '0;
            done      <= '0;
            vld_p     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) own_p[i] <= '0;
        end else begin
            req_ready <= '0;
            done      <= '0;
            bram_en   <= 1'b0;

            // Return pipeline: stage 0 follows the issued strobe, last stage retires to rd_*
            vld_p[0] <= bram_en;
            own_p[0] <= owner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                own_p[i] <= own_p[i-1];
            end
            rd_data  <= bram_data;
            rd_valid <= vld_p[READ_LATENCY-1] ? onehot(own_p[READ_LATENCY-1]) : '0;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        req_ready <= onehot(grant_idx);
                        owner     <= grant_idx;
                        cur_addr  <= grant_addr;
                        remaining <= grant_len;
`ifndef ARB_FIXED_PRIO_EN
                        rr_ptr    <= next_ptr;
`endif
                        state     <= (grant_len == '0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (!owner_hold) begin
                        bram_en   <= 1'b1;
                        bram_addr <= cur_addr;
                        cur_addr  <= cur_addr + STRIDE;
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        done  <= onehot(owner);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: directed and randomized bursts checked against a cycle-level model of grants, issues and returns.
module tb_bram_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int LW = 10;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     bram_addr;
    logic              bram_en;
    logic [DW-1:0]     bram_data;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     hold;
    logic [DW-1:0]     rd_data;
    logic [NR-1:0]     rd_valid;
    logic [NR-1:0]     done;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    bram_read_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .LEN_WIDTH(LW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset), .bram_addr(bram_addr), .bram_en(bram_en), .bram_data(bram_data),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .hold(hold), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hA5C3_0F1E;
    endfunction

    // BRAM model: data for an address appears RL cycles after it is presented
    logic [AW-1:0] bpipe [RL];
    always @(posedge clk) begin
        bpipe[0] <= bram_addr;
        for (int i = 1; i < RL; i++) bpipe[i] <= bpipe[i-1];
    end
    assign bram_data = mem_word(bpipe[RL-1]);

    int cyc = 0;
    logic [NR-1:0] hold_hist [0:16383];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < 16384) hold_hist[cyc] = hold;
    end

    int          iss_c[$];
    logic [31:0] iss_a[$];
    int          rv_c[$];
    int          rv_o[$];
    logic [31:0] rv_d[$];
    int          dn_c[$];
    int          dn_o[$];
    int          rq_c[$];
    int          rq_o[$];

    always @(negedge clk) begin
        if (bram_en === 1'b1) begin
            iss_c.push_back(cyc);
            iss_a.push_back(bram_addr);
        end
        for (int i = 0; i < NR; i++) begin
            if (rd_valid[i] === 1'b1) begin
                rv_c.push_back(cyc); rv_o.push_back(i); rv_d.push_back(rd_data);
            end
            if (done[i] === 1'b1) begin
                dn_c.push_back(cyc); dn_o.push_back(i);
            end
            if (req_ready[i] === 1'b1) begin
                rq_c.push_back(cyc); rq_o.push_back(i);
            end
        end
    end

    function automatic int at_i(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [31:0] at_a(input logic [31:0] q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_bram_addr"}, 64'(bram_addr), 64'd0);
        chk({pfx, "_bram_en"},   64'(bram_en),   64'd0);
        chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({pfx, "_rd_data"},   64'(rd_data),   64'd0);
        chk({pfx, "_rd_valid"},  64'(rd_valid),  64'd0);
        chk({pfx, "_done"},      64'(done),      64'd0);
        chk({pfx, "_busy"},      64'(busy),      64'd0);
    endtask

    // Model: grants start the cycle after the request; each burst issues one word per unheld cycle,
    // returns it RL+1 cycles later, pulses done with the last word, and the next grant follows done.
    task automatic check_round(input int s, input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                               input int l0, input int l1, input int b_iss, input int b_rv, input int b_dn, input int b_rq);
        int order[2];
        int n, acc, c, dcyc, ki, kr, who, len;
        logic [31:0] base, ea;
        if (mask == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            order[0] = 0;
`else
            order[0] = m_ptr;
`endif
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = mask[1] ? 1 : 0;
            order[1] = 0;
            n = 1;
        end
        acc = s + 1; ki = b_iss; kr = b_rv;
        for (int g = 0; g < n; g++) begin
            who   = order[g];
            m_ptr = (who + 1) % NR;
            base  = who ? a1 : a0;
            len   = who ? l1 : l0;
            chk("grant_owner", 64'(at_i(rq_o, b_rq + g)), 64'(who));
            chk("grant_cycle", 64'(at_i(rq_c, b_rq + g)), 64'(acc));
            c = acc + 1; dcyc = acc + 1;
            for (int w = 0; w < len; w++) begin
                while (hold_hist[c][who] === 1'b1 && c < acc + 1000) c++;
                ea = base + 32'(4 * w);
                chk("issue_addr",  64'(at_a(iss_a, ki)), 64'(ea));
                chk("issue_cycle", 64'(at_i(iss_c, ki)), 64'(c));
                chk("rd_cycle",    64'(at_i(rv_c, kr)),  64'(c + RL + 1));
                chk("rd_owner",    64'(at_i(rv_o, kr)),  64'(who));
                chk("rd_data",     64'(at_a(rv_d, kr)),  64'(mem_word(ea)));
                dcyc = c + RL + 1;
                ki++; kr++; c++;
            end
            chk("done_cycle", 64'(at_i(dn_c, b_dn + g)), 64'(dcyc));
            chk("done_owner", 64'(at_i(dn_o, b_dn + g)), 64'(who));
            acc = dcyc + 1;
        end
        chk("issue_count", 64'(iss_c.size() - b_iss), 64'(ki - b_iss));
        chk("rd_count",    64'(rv_c.size() - b_rv),   64'(kr - b_rv));
        chk("done_count",  64'(dn_c.size() - b_dn),   64'(n));
        chk("grant_count", 64'(rq_c.size() - b_rq),   64'(n));
    endtask

    task automatic run_round(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                             input int l0, input int l1, input int hreq, input int hat, input int hlen);
        int s, need, dones, seen, hleft, b_iss, b_rv, b_dn, b_rq;
        bit armed;
        @(negedge clk);
        b_iss = iss_c.size(); b_rv = rv_c.size(); b_dn = dn_c.size(); b_rq = rq_c.size();
        req_addr  = {a1, a0};
        req_len   = {LW'(l1), LW'(l0)};
        req_valid = mask;
        s = cyc;
        need  = int'(mask[0]) + int'(mask[1]);
        dones = 0; seen = 0; hleft = 0; armed = (hreq >= 0);
        for (int t = 0; t < 600 && dones < need; t++) begin
            @(negedge clk);
            req_valid = req_valid & ~req_ready;
            if (hleft > 0) begin
                hleft--;
                if (hleft == 0) hold = '0;
            end
            if (bram_en === 1'b1) seen++;
            if (armed && bram_en === 1'b1 && seen == hat) begin
                hold[hreq] = 1'b1;
                hleft = hlen;
                armed = 1'b0;
            end
            dones += int'(done[0]) + int'(done[1]);
        end
        chk("round_done", 64'(dones), 64'(need));
        hold = '0;
        req_valid = '0;
        repeat (RL + 3) @(negedge clk);
        check_round(s, mask, a0, a1, l0, l1, b_iss, b_rv, b_dn, b_rq);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, b_rv, b_dn, b_iss, n0;
        reset = 1'b1; hold = '0; req_valid = '0; req_addr = '0; req_len = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Simultaneous requests from reset release, then repeated to see alternation
        for (int r = 0; r < 4; r++)
            run_round(2'b11, 32'h1000_0000 + 32'(r * 64), 32'h2000_0000 + 32'(r * 64), 2, 2, -1, 0, 0);

        // Single 9-word burst
        n0 = iss_c.size();
        run_round(2'b01, 32'hB000_0000, 32'h0, 9, 0, -1, 0, 0);
        chk("t1_first_addr", 64'(at_a(iss_a, n0)), 64'h0000_0000_B000_0000);
        chk("t1_last_addr",  64'(at_a(iss_a, n0 + 8)), 64'h0000_0000_B000_0020);

        // Hold for 3 cycles after the 2nd issue
        n0 = iss_c.size();
        run_round(2'b10, 32'h0, 32'h0000_4000, 0, 4, 1, 2, 3);
        chk("t3_gap", 64'(at_i(iss_c, n0 + 3) - at_i(iss_c, n0) + 1 - 4), 64'd3);

        // Zero-length request
        run_round(2'b01, 32'h0000_8000, 32'h0, 0, 0, -1, 0, 0);

        // Address wrap
        n0 = iss_c.size();
        run_round(2'b01, 32'hFFFF_FFFC, 32'h0, 2, 0, -1, 0, 0);
        chk("t6_wrap_addr", 64'(at_a(iss_a, n0 + 1)), 64'h0);

        // Randomized rounds
        for (int r = 0; r < 14; r++) begin
            logic [1:0] m;
            logic [31:0] x0, x1;
            int y0, y1, hr, ha, hl;
            m  = 2'($urandom_range(1, 3));
            x0 = $urandom & 32'hFFFF_FFFC;
            x1 = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) x0 = 32'hFFFF_FFF4;
            y0 = $urandom_range(0, 7);
            y1 = $urandom_range(0, 7);
            hr = -1; ha = 0; hl = 0;
            if ($urandom_range(0, 1) == 1) begin
                hr = $urandom_range(0, 1);
                ha = $urandom_range(1, 4);
                hl = $urandom_range(1, 3);
            end
            run_round(m, x0, x1, y0, y1, hr, ha, hl);
        end

        // Reset during the 3rd word of an 8-word burst
        @(negedge clk);
        req_addr[AW-1:0] = 32'hC000_0100;
        req_len[LW-1:0]  = LW'(8);
        req_valid = 2'b01;
        seen = 0;
        for (int t = 0; t < 60 && seen < 3; t++) begin
            @(negedge clk);
            req_valid = req_valid & ~req_ready;
            if (bram_en === 1'b1) seen++;
        end
        chk("abort_reach", 64'(seen), 64'd3);
        b_rv = rv_c.size(); b_dn = dn_c.size();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("abort");
        b_iss = iss_c.size();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (RL + 4) @(negedge clk);
        chk("abort_no_rd",    64'(rv_c.size() - b_rv),   64'd0);
        chk("abort_no_done",  64'(dn_c.size() - b_dn),   64'd0);
        chk("abort_no_issue", 64'(iss_c.size() - b_iss), 64'd0);
        m_ptr = 0;

        // Normal operation after the abort
        run_round(2'b11, 32'h0000_0040, 32'h0000_0080, 3, 3, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
